// File: rtl/seqdet_pkg.sv
// Shared constants and elaboration-time helpers for the
// parameterised serial pattern detector.
package seqdet_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;

  function automatic int state_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // Pattern bit i (i = 0 is received first) lives at pat[w-1-i].
  function automatic int kmp_next(
    input logic [31:0] pat,
    input int          w,
    input int          k,
    input logic        b
  );
    int  lmax;
    int  pos;
    int  best;
    logic ok;
    logic tb;
    best = 0;
    lmax = (k + 1 < w) ? k + 1 : w - 1;
    for (int l = lmax; l >= 1; l--) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        pos = k + 1 - l + j;
        tb  = (pos == k) ? b : pat[w-1-pos];
        if (pat[w-1-j] != tb) ok = 1'b0;
      end
      if (ok && best == 0) best = l;
    end
    return best;
  endfunction

endpackage

// File: rtl/seqdet_next.sv
// Combinational next-state and match decode for the detector,
// backed by a KMP transition table built at elaboration.
module seqdet_next
  import seqdet_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  localparam int              SW      = state_w(PAT_W)
) (
  input  logic [SW-1:0] s_i,
  input  logic          x_i,
  input  logic          overlap_i,
  output logic [SW-1:0] s_next_o,
  output logic          hit_o
);

  localparam int          NS    = 1 << SW;
  localparam logic [31:0] PAT32 = 32'(PATTERN);
  localparam int          FAILS =
    kmp_next(PAT32, PAT_W, PAT_W - 1, PATTERN[0]);
  localparam logic [SW-1:0] LAST = SW'(PAT_W - 1);

  logic [SW-1:0] tab0 [NS];
  logic [SW-1:0] tab1 [NS];

  // Codes at or above PAT_W are unreachable; they fall back to S0.
  for (genvar k = 0; k < NS; k++) begin : g_tab
    if (k < PAT_W) begin : g_live
      localparam int N0 = kmp_next(PAT32, PAT_W, k, 1'b0);
      localparam int N1 = kmp_next(PAT32, PAT_W, k, 1'b1);
      assign tab0[k] = SW'(N0);
      assign tab1[k] = SW'(N1);
    end else begin : g_dead
      assign tab0[k] = '0;
      assign tab1[k] = '0;
    end
  end

  always_comb begin
    hit_o    = (s_i == LAST) && (x_i == PATTERN[0]);
    s_next_o = x_i ? tab1[s_i] : tab0[s_i];
    if (hit_o) begin
      s_next_o = overlap_i ? SW'(FAILS) : '0;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with overlap mode, registered match
// pulse and saturating match counter.
module seq_detect_param
  import seqdet_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8,
  localparam int              SW      = state_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  output logic             y,
  output logic [SW-1:0]    s,
  output logic [CNT_W-1:0] match_cnt
);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX
      || CNT_W < 1) begin : g_bad_param
    $fatal(1, "seq_detect_param: illegal PAT_W/CNT_W");
  end

  logic [SW-1:0]    s_q;
  logic [SW-1:0]    s_d;
  logic             y_q;
  logic             hit;
  logic [CNT_W-1:0] cnt_q;

  seqdet_next #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN)
  ) u_next (
    .s_i      (s_q),
    .x_i      (x),
    .overlap_i(overlap),
    .s_next_o (s_d),
    .hit_o    (hit)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s_q   <= '0;
      y_q   <= 1'b0;
      cnt_q <= '0;
    end else if (en) begin
      s_q <= s_d;
      y_q <= hit;
      if (hit && cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      y_q <= 1'b0;
    end
  end

  assign y         = y_q;
  assign s         = s_q;
  assign match_cnt = cnt_q;

endmodule
